// File: rtl/led_sequence_driver.sv
// led_sequence_driver: shows one handshaken item for a timed ON window and a dark gap,
// then pulses show_done. Also runs an all-LED blink pattern, which pre-empts any show.
module led_sequence_driver #(
    parameter int DATA_WIDTH   = 4,
    parameter int ON_CYCLES    = 25000000,
    parameter int OFF_CYCLES   = 12500000,
    parameter int BLINK_CYCLES = 12500000,
    parameter int BLINK_COUNT  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  show_valid,
    input  logic [DATA_WIDTH-1:0] show_item,
    output logic                  show_ready,
    input  logic                  speed,
    input  logic                  blink_req,
    output logic [DATA_WIDTH-1:0] leds,
    output logic                  busy,
    output logic                  show_done,
    output logic                  blink_done
);
    localparam int MAX_ON_OFF = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int MAX_C = MAX_ON_OFF > BLINK_CYCLES ? MAX_ON_OFF : BLINK_CYCLES;
    localparam int CW = $clog2(MAX_C + 1);
    localparam int BW = $clog2(BLINK_COUNT + 1);
    localparam logic [CW-1:0] ON_F = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] ON_H = CW'(ON_CYCLES / 2 - 1);
    // The show_done cycle is the last dark cycle, so SHOW_OFF itself lasts one cycle less.
    localparam logic [CW-1:0] OFF_F = CW'(OFF_CYCLES >= 2 ? OFF_CYCLES - 2 : 0);
    localparam logic [CW-1:0] OFF_H = CW'(OFF_CYCLES / 2 >= 2 ? OFF_CYCLES / 2 - 2 : 0);
    localparam logic [CW-1:0] BL = CW'(BLINK_CYCLES - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(BLINK_COUNT - 1);

    typedef enum logic [2:0] {IDLE, SHOW_ON, SHOW_OFF, BLINK_ON, BLINK_OFF} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           count, count_n;
    logic [BW-1:0]           blinks, blinks_n;
    logic                    fast, fast_n;
    logic [DATA_WIDTH-1:0]   leds_n;
    logic                    show_done_n, blink_done_n;

    assign show_ready = (state == IDLE) && !blink_req;
    assign busy       = state != IDLE;

    always_comb begin
        state_n      = state;
        count_n      = count;
        blinks_n     = blinks;
        fast_n       = fast;
        leds_n       = leds;
        show_done_n  = 1'b0;
        blink_done_n = 1'b0;
        if (blink_req) begin
            state_n  = BLINK_ON;
            leds_n   = '1;
            count_n  = BL;
            blinks_n = '0;
        end else begin
            case (state)
                IDLE: if (show_valid) begin
                    state_n = SHOW_ON;
                    leds_n  = show_item;
                    fast_n  = speed;
                    count_n = speed ? ON_H : ON_F;
                end
                SHOW_ON: if (count == '0) begin
                    state_n = SHOW_OFF;
                    leds_n  = '0;
                    count_n = fast ? OFF_H : OFF_F;
                end else count_n = count - 1'b1;
                SHOW_OFF: if (count == '0) begin
                    state_n     = IDLE;
                    show_done_n = 1'b1;
                end else count_n = count - 1'b1;
                BLINK_ON: if (count == '0) begin
                    state_n = BLINK_OFF;
                    leds_n  = '0;
                    count_n = BL;
                end else count_n = count - 1'b1;
                BLINK_OFF: if (count == '0) begin
                    if (blinks == BC_LAST) begin
                        state_n      = IDLE;
                        blink_done_n = 1'b1;
                    end else begin
                        state_n  = BLINK_ON;
                        leds_n   = '1;
                        count_n  = BL;
                        blinks_n = blinks + 1'b1;
                    end
                end else count_n = count - 1'b1;
                default: begin
                    state_n = IDLE;
                    leds_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            blinks     <= '0;
            fast       <= 1'b0;
            leds       <= '0;
            show_done  <= 1'b0;
            blink_done <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            blinks     <= blinks_n;
            fast       <= fast_n;
            leds       <= leds_n;
            show_done  <= show_done_n;
            blink_done <= blink_done_n;
        end
    end
endmodule

// File: tb/tb_led_sequence_driver.sv
// tb_led_sequence_driver: randomized and directed checks against a frame-queue model
// that lists the LED/pulse values expected after each upcoming clock edge.
module tb_led_sequence_driver;
    localparam int ON = 8, OFF = 4, BLC = 3, BCNT = 2;

    logic       clk = 1'b0, rst = 1'b1;
    logic       show_valid = 1'b0, speed = 1'b0, blink_req = 1'b0;
    logic [3:0] show_item = '0;
    logic       show_ready, busy, show_done, blink_done;
    logic [3:0] leds;

    led_sequence_driver #(
        .DATA_WIDTH(4), .ON_CYCLES(ON), .OFF_CYCLES(OFF),
        .BLINK_CYCLES(BLC), .BLINK_COUNT(BCNT)
    ) dut (
        .clk(clk), .rst(rst), .show_valid(show_valid), .show_item(show_item),
        .show_ready(show_ready), .speed(speed), .blink_req(blink_req),
        .leds(leds), .busy(busy), .show_done(show_done), .blink_done(blink_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [3:0] leds; logic sd; logic bd;} frame_t;
    frame_t q[$];
    frame_t cur;
    int checks = 0, errors = 0, cyc = 0, last_done = -1;
    int dones[$];
    logic accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // A show is T_on lit frames, then T_off dark frames, the last carrying show_done.
    task automatic push_show(input logic [3:0] it, input logic sp);
        int t_on, t_off;
        t_on  = sp ? ON / 2 : ON;
        t_off = sp ? OFF / 2 : OFF;
        for (int i = 0; i < t_on; i++) q.push_back('{it, 1'b0, 1'b0});
        for (int i = 0; i < t_off - 1; i++) q.push_back('{4'h0, 1'b0, 1'b0});
        q.push_back('{4'h0, 1'b1, 1'b0});
    endtask

    task automatic push_blink();
        for (int b = 0; b < BCNT; b++) begin
            for (int i = 0; i < BLC; i++) q.push_back('{4'hf, 1'b0, 1'b0});
            for (int i = 0; i < BLC; i++) q.push_back('{4'h0, 1'b0, 1'b0});
        end
        q.push_back('{4'h0, 1'b0, 1'b1});
    endtask

    task automatic step(input logic v, input logic [3:0] it, input logic sp, input logic br);
        show_valid = v; show_item = it; speed = sp; blink_req = br;
        #1 check("show_ready", 32'(show_ready), 32'(q.size() == 0 && !br));
        @(posedge clk);
        accepted = 1'b0;
        if (br) begin
            q.delete();
            push_blink();
        end else if (q.size() == 0 && v) begin
            push_show(it, sp);
            accepted = 1'b1;
        end
        cur = q.size() != 0 ? q.pop_front() : '0;
        cyc++;
        @(negedge clk);
        check("leds", 32'(leds), 32'(cur.leds));
        check("show_done", 32'(show_done), 32'(cur.sd));
        check("blink_done", 32'(blink_done), 32'(cur.bd));
        check("busy", 32'(busy), 32'(q.size() != 0));
        if (show_done) begin
            last_done = cyc;
            dones.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int a;
        logic [3:0] items [3];
        repeat (2) @(negedge clk);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_ready", 32'(show_ready), 32'h1);
        rst = 1'b0;
        // Async reset in the middle of SHOW_ON, observed before any clock edge
        step(1'b1, 4'b1010, 1'b0, 1'b0);
        idle(2);
        #2 rst = 1'b1;
        show_valid = 1'b0;
        #1;
        check("async_leds", 32'(leds), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        check("async_ready", 32'(show_ready), 32'h1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        // Normal speed show
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        a = cyc;
        idle(ON + OFF);
        check("done_latency_slow", 32'(last_done - a), 32'(ON + OFF - 1));
        // Fast show, speed toggled mid-show
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        a = cyc;
        step(1'b0, 4'hf, 1'b0, 1'b0);
        step(1'b0, 4'h3, 1'b1, 1'b0);
        step(1'b0, 4'h7, 1'b0, 1'b0);
        idle(5);
        check("done_latency_fast", 32'(last_done - a), 32'(ON / 2 + OFF / 2 - 1));
        // Back-to-back with show_valid held
        items = '{4'h1, 4'h2, 4'h4};
        dones.delete();
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            do begin
                step(1'b1, items[i], 1'b0, 1'b0);
                n++;
            end while (!accepted && n < 30);
            check("b2b_accept", 32'(accepted), 32'h1);
        end
        idle(ON + OFF + 2);
        check("b2b_count", 32'(dones.size()), 32'd3);
        if (dones.size() == 3) begin
            check("b2b_gap1", 32'(dones[1] - dones[0]), 32'(ON + OFF));
            check("b2b_gap2", 32'(dones[2] - dones[1]), 32'(ON + OFF));
        end
        // Blink aborts a show
        dones.delete();
        step(1'b1, 4'h6, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        idle(2 * BLC * BCNT + 3);
        check("abort_no_done", 32'(dones.size()), 32'h0);
        // Blink and show requested together in IDLE
        step(1'b1, 4'hf, 1'b0, 1'b1);
        check("blink_over_show", 32'(accepted), 32'h0);
        idle(2 * BLC * BCNT + 3);
        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0));
        idle(ON + OFF + 2 * BLC * BCNT + 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
